// File: rtl/rx_uart_if.sv
// Handshake/data bundle between the serial pin side and the rx_uart receiver.
// o_parity_err exists only when RX_UART_PARITY_EN is defined.
interface rx_uart_if #(
  parameter int DBIT = 8
);
  logic            i_rx;
  logic            i_s_tick;
  logic [DBIT-1:0] o_data;
  logic            o_rx_done_tick;
  logic            o_frame_err;
`ifdef RX_UART_PARITY_EN
  logic            o_parity_err;
`endif

  modport master (
    output i_rx,
    output i_s_tick,
    input  o_data,
    input  o_rx_done_tick,
    input  o_frame_err
`ifdef RX_UART_PARITY_EN
    , input o_parity_err
`endif
  );

  modport slave (
    input  i_rx,
    input  i_s_tick,
    output o_data,
    output o_rx_done_tick,
    output o_frame_err
`ifdef RX_UART_PARITY_EN
    , output o_parity_err
`endif
  );
endinterface

// File: rtl/rx_uart.sv
// 16x-oversampled UART receiver: 1 start, DBIT data bits LSB first, optional parity, stop.
// Define RX_UART_PARITY_EN to add an even-parity bit and the o_parity_err flag.
module rx_uart #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int NB_STATE = 3
) (
  input logic      i_clock,
  input logic      i_reset,
  rx_uart_if.slave bus
);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam logic [SW-1:0] S_MID     = SW'(7);
  localparam logic [SW-1:0] S_LAST    = SW'(15);
  localparam logic [SW-1:0] S_STOPEND = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  typedef enum logic [NB_STATE-1:0] {
    S_IDLE   = NB_STATE'(0),
    S_START  = NB_STATE'(1),
    S_DATA   = NB_STATE'(2),
`ifdef RX_UART_PARITY_EN
    S_PARITY = NB_STATE'(3),
`endif
    S_STOP   = NB_STATE'(4)
  } state_t;

  state_t          r_state;
  logic            r_sync1, r_sync2, r_hist;
  logic [SW-1:0]   r_s_cnt;
  logic [NW-1:0]   r_n_cnt;
  logic [DBIT-1:0] r_shreg;
  logic [DBIT-1:0] r_data;
  logic            r_done;
  logic            r_frame_err;
`ifdef RX_UART_PARITY_EN
  logic            r_par;
  logic            r_parity_err;
`endif
  logic            w_fall;

  // Only a high-to-low transition starts a frame; a line stuck low stays idle.
  assign w_fall = r_hist & ~r_sync2;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_hist      <= 1'b1;
      r_s_cnt     <= '0;
      r_n_cnt     <= '0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef RX_UART_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_sync1 <= bus.i_rx;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_s_cnt <= '0;
          end
        end
        S_START: begin
          if (bus.i_s_tick) begin
            if (r_s_cnt == S_MID) begin
              r_s_cnt <= '0;
              r_n_cnt <= '0;
              r_state <= r_sync2 ? S_IDLE : S_DATA;
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
        S_DATA: begin
          if (bus.i_s_tick) begin
            if (r_s_cnt == S_LAST) begin
              r_s_cnt <= '0;
              r_shreg <= {r_sync2, r_shreg[DBIT-1:1]};
              if (r_n_cnt == N_LAST) begin
`ifdef RX_UART_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end else begin
                r_n_cnt <= r_n_cnt + NW'(1);
              end
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
`ifdef RX_UART_PARITY_EN
        S_PARITY: begin
          if (bus.i_s_tick) begin
            if (r_s_cnt == S_LAST) begin
              r_par   <= r_sync2;
              r_s_cnt <= '0;
              r_state <= S_STOP;
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
`endif
        S_STOP: begin
          if (bus.i_s_tick) begin
            if (r_s_cnt == S_STOPEND) begin
              // Data is delivered even on a framing error; the flag tells the consumer.
              r_data      <= r_shreg;
              r_frame_err <= ~r_sync2;
`ifdef RX_UART_PARITY_EN
              r_parity_err <= (^r_shreg) ^ r_par;
`endif
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_data         = r_data;
  assign bus.o_rx_done_tick = r_done;
  assign bus.o_frame_err    = r_frame_err;
`ifdef RX_UART_PARITY_EN
  assign bus.o_parity_err   = r_parity_err;
`endif
endmodule
